// File: rtl/alu_seq_ctrl.sv
// Command sequencer driving one shared and/or/add ALU: single-pass ops in one
// execute cycle, MUL as WIDTH shift-add iterations; one command in flight.
module alu_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_carry_in,
  output logic             alu_invert1,
  output logic             alu_invert2,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  localparam logic [2:0] CMD_AND = 3'd0;
  localparam logic [2:0] CMD_OR  = 3'd1;
  localparam logic [2:0] CMD_ADD = 3'd2;
  localparam logic [2:0] CMD_SUB = 3'd3;
  localparam logic [2:0] CMD_NOR = 3'd4;
  localparam logic [2:0] CMD_SLT = 3'd5;
  localparam logic [2:0] CMD_MUL = 3'd6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam int MSB = WIDTH - 1;

  state_t           state, state_next;
  logic [2:0]       cmd_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_next;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] exec_result;
  logic             exec_carry, exec_ovf, exec_err;
  logic             add_ovf, sub_ovf;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // SUB feeds ~b into the adder, so its overflow test compares a against ~b.
  assign add_ovf  = (a_q[MSB] == b_q[MSB])  && (alu_result[MSB] != a_q[MSB]);
  assign sub_ovf  = (a_q[MSB] == ~b_q[MSB]) && (alu_result[MSB] != a_q[MSB]);
  assign acc_next = mplier[0] ? alu_result : acc;

  always_comb begin
    state_next   = state;
    alu_in1      = '0;
    alu_in2      = '0;
    alu_carry_in = 1'b0;
    alu_invert1  = 1'b0;
    alu_invert2  = 1'b0;
    alu_op       = 2'd3;
    exec_result  = '0;
    exec_carry   = 1'b0;
    exec_ovf     = 1'b0;
    exec_err     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_next = (req_cmd == CMD_MUL) ? MUL : EXEC;
      end
      EXEC: begin
        alu_in1    = a_q;
        alu_in2    = b_q;
        state_next = RESP;
        case (cmd_q)
          CMD_AND: begin
            alu_op      = 2'd0;
            exec_result = alu_result;
          end
          CMD_OR: begin
            alu_op      = 2'd1;
            exec_result = alu_result;
          end
          CMD_ADD: begin
            alu_op      = 2'd2;
            exec_result = alu_result;
            exec_carry  = alu_carry_out;
            exec_ovf    = add_ovf;
          end
          CMD_SUB: begin
            alu_op       = 2'd2;
            alu_invert2  = 1'b1;
            alu_carry_in = 1'b1;
            exec_result  = alu_result;
            exec_carry   = alu_carry_out;
            exec_ovf     = sub_ovf;
          end
          CMD_NOR: begin
            alu_op      = 2'd0;
            alu_invert1 = 1'b1;
            alu_invert2 = 1'b1;
            exec_result = alu_result;
          end
          CMD_SLT: begin
            alu_op       = 2'd2;
            alu_invert2  = 1'b1;
            alu_carry_in = 1'b1;
            exec_result  = {{(WIDTH-1){1'b0}}, alu_result[MSB] ^ sub_ovf};
            exec_carry   = alu_carry_out;
          end
          default: begin
            alu_op   = 2'd3;
            exec_err = 1'b1;
          end
        endcase
      end
      MUL: begin
        alu_in1 = acc;
        alu_in2 = mcand;
        alu_op  = 2'd2;
        if (cnt == LAST) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_q  <= req_cmd;
            a_q    <= req_a;
            b_q    <= req_b;
            acc    <= '0;
            mcand  <= req_a;
            mplier <= req_b;
            cnt    <= '0;
          end
        end
        EXEC: begin
          rsp_result <= exec_result;
          rsp_zero   <= (exec_result == '0);
          rsp_carry  <= exec_carry;
          rsp_ovf    <= exec_ovf;
          rsp_err    <= exec_err;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            rsp_result <= acc_next;
            rsp_zero   <= (acc_next == '0);
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
